// File: rtl/hazard_tracker_if.sv
// ID-stage request signals and stage-tracking results exchanged between
// the decode logic (master) and the hazard tracker (slave).
interface hazard_tracker_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_memop;
  logic             flush;
  logic             mem_ready;
  logic             cnt_clr;

  logic             stall;
  logic             bubble;
  logic             freeze;
  logic [REG_W-1:0] id_ex_rd;
  logic [REG_W-1:0] ex_mem_rd;
  logic [REG_W-1:0] mem_wb_rd;
  logic             id_ex_regwrite;
  logic             ex_mem_regwrite;
  logic             mem_wb_regwrite;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_regwrite, id_memread, id_memop, flush, mem_ready, cnt_clr,
    input  stall, bubble, freeze, id_ex_rd, ex_mem_rd, mem_wb_rd,
           id_ex_regwrite, ex_mem_regwrite, mem_wb_regwrite, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_regwrite, id_memread, id_memop, flush, mem_ready, cnt_clr,
    output stall, bubble, freeze, id_ex_rd, ex_mem_rd, mem_wb_rd,
           id_ex_regwrite, ex_mem_regwrite, mem_wb_regwrite, stall_count
  );
endinterface

// File: rtl/hazard_tracker.sv
// Destination-register shadow of ID/EX, EX/MEM, MEM/WB with load-use stall,
// flush bubbling, memory freeze and a saturating stall-cycle counter.
module hazard_tracker #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  hazard_tracker_if.slave hz
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
    logic             memop;
  } rec_t;

  rec_t ex_r, mem_r, wb_r;
  rec_t ex_next;
  logic freeze;
  logic load_use;
  logic stall;
  logic bubble;
  logic [CNT_W-1:0] count_r;

  assign freeze = mem_r.valid & mem_r.memop & ~hz.mem_ready;

  assign load_use = hz.id_valid & ex_r.valid & ex_r.memread & ex_r.regwrite &
                    ((hz.id_uses_rs & (hz.id_rs == ex_r.rd)) |
                     (hz.id_uses_rt & (hz.id_rt == ex_r.rd)));

  assign stall  = ~freeze & load_use & ~hz.flush;
  assign bubble = ~freeze & (stall | hz.flush | ~hz.id_valid);

  always_comb begin
    ex_next = '0;
    if (!bubble) begin
      ex_next.valid    = 1'b1;
      ex_next.rd       = hz.id_rd;
      // $0 is hardwired, so it is never treated as a live destination
      ex_next.regwrite = hz.id_regwrite & hz.id_valid & (hz.id_rd != '0);
      ex_next.memread  = hz.id_memread;
      ex_next.memop    = hz.id_memop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else if (!freeze) begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      ex_r  <= ex_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (hz.cnt_clr) begin
      count_r <= '0;
    end else if ((stall | freeze) && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + 1'b1;
    end
  end

  assign hz.stall           = stall;
  assign hz.bubble          = bubble;
  assign hz.freeze          = freeze;
  assign hz.id_ex_rd        = ex_r.rd;
  assign hz.ex_mem_rd       = mem_r.rd;
  assign hz.mem_wb_rd       = wb_r.rd;
  assign hz.id_ex_regwrite  = ex_r.regwrite;
  assign hz.ex_mem_regwrite = mem_r.regwrite;
  assign hz.mem_wb_regwrite = wb_r.regwrite;
  assign hz.stall_count     = count_r;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: reset, load-use, freeze, flush, $0,
// counter clear priority and saturation on a narrow-counter instance.
module tb_hazard_tracker;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  hazard_tracker_if #(.REG_W(5), .CNT_W(16)) hz ();
  hazard_tracker_if #(.REG_W(5), .CNT_W(4))  hz4 ();

  hazard_tracker #(.REG_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  hazard_tracker #(.REG_W(5), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_idle();
    hz.id_valid = 0; hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rs = 0;
    hz.id_uses_rt = 0; hz.id_rd = 0; hz.id_regwrite = 0;
    hz.id_memread = 0; hz.id_memop = 0; hz.flush = 0;
  endtask

  task automatic id_load(input logic [4:0] rd);
    id_idle();
    hz.id_valid = 1; hz.id_rs = 5'd2; hz.id_uses_rs = 1; hz.id_rd = rd;
    hz.id_regwrite = 1; hz.id_memread = 1; hz.id_memop = 1;
  endtask

  task automatic id_add(input logic [4:0] rd, input logic [4:0] rs, input logic use_rs,
                        input logic [4:0] rt, input logic use_rt);
    id_idle();
    hz.id_valid = 1; hz.id_rs = rs; hz.id_uses_rs = use_rs;
    hz.id_rt = rt; hz.id_uses_rt = use_rt; hz.id_rd = rd; hz.id_regwrite = 1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 0;
    id_idle();
    hz.mem_ready = 1; hz.cnt_clr = 0;
    hz4.id_valid = 0; hz4.id_rs = 0; hz4.id_rt = 0; hz4.id_uses_rs = 0;
    hz4.id_uses_rt = 0; hz4.id_rd = 0; hz4.id_regwrite = 0;
    hz4.id_memread = 0; hz4.id_memop = 0; hz4.flush = 0;
    hz4.mem_ready = 1; hz4.cnt_clr = 0;
    #12;
    check("rst_ex_rd", hz.id_ex_rd, 0);
    check("rst_wb_we", hz.mem_wb_regwrite, 0);
    check("rst_stall", hz.stall, 0);
    check("rst_freeze", hz.freeze, 0);
    check("rst_bubble", hz.bubble, 1);
    check("rst_count", hz.stall_count, 0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // load-use on rs
    id_load(5'd8); #1;
    check("lu_pre_stall", hz.stall, 0);
    check("lu_pre_bubble", hz.bubble, 0);
    tick();
    id_add(5'd9, 5'd8, 1, 5'd3, 0); #1;
    check("lu_stall", hz.stall, 1);
    check("lu_bubble", hz.bubble, 1);
    tick();
    check("lu_stall_n1", hz.stall, 0);
    check("lu_bubble_n1", hz.bubble, 0);
    check("lu_ex_bub_we", hz.id_ex_regwrite, 0);
    check("lu_mem_rd", hz.ex_mem_rd, 8);
    tick();
    check("lu_wb_rd", hz.mem_wb_rd, 8);
    check("lu_wb_we", hz.mem_wb_regwrite, 1);
    check("lu_ex_rd", hz.id_ex_rd, 9);
    check("lu_count", hz.stall_count, 1);
    id_idle();
    tick(); tick(); tick();

    // same registers, but rs not read: no hazard
    id_load(5'd8);
    tick();
    id_add(5'd9, 5'd8, 0, 5'd3, 1); #1;
    check("nolu_stall", hz.stall, 0);
    tick();
    check("nolu_ex_rd", hz.id_ex_rd, 9);
    check("nolu_mem_rd", hz.ex_mem_rd, 8);
    id_idle();
    tick(); tick(); tick();

    // memory freeze for 3 cycles
    hz.cnt_clr = 1;
    tick();
    hz.cnt_clr = 0;
    check("clr_count", hz.stall_count, 0);
    id_load(5'd5);
    tick();
    id_idle();
    tick();
    hz.mem_ready = 0; #1;
    for (int i = 0; i < 3; i++) begin
      check("frz_freeze", hz.freeze, 1);
      check("frz_bubble", hz.bubble, 0);
      check("frz_mem_rd", hz.ex_mem_rd, 5);
      check("frz_wb_rd", hz.mem_wb_rd, 0);
      tick();
    end
    hz.mem_ready = 1; #1;
    check("frz_release", hz.freeze, 0);
    check("frz_count", hz.stall_count, 3);
    tick();
    check("frz_adv_wb", hz.mem_wb_rd, 5);
    check("frz_adv_mem", hz.ex_mem_rd, 0);
    tick(); tick();

    // load-use pending under a 2-cycle freeze
    hz.cnt_clr = 1;
    tick();
    hz.cnt_clr = 0;
    id_load(5'd6);
    tick();
    id_load(5'd7);
    tick();
    id_add(5'd9, 5'd7, 1, 5'd0, 0);
    hz.mem_ready = 0; #1;
    for (int i = 0; i < 2; i++) begin
      check("fl_freeze", hz.freeze, 1);
      check("fl_stall", hz.stall, 0);
      check("fl_ex_rd", hz.id_ex_rd, 7);
      tick();
    end
    hz.mem_ready = 1; #1;
    check("fl_after_stall", hz.stall, 1);
    check("fl_after_bubble", hz.bubble, 1);
    tick();
    check("fl_stall_once", hz.stall, 0);
    check("fl_count", hz.stall_count, 3);
    tick();
    check("fl_dep_ex", hz.id_ex_rd, 9);
    check("fl_wb_rd", hz.mem_wb_rd, 7);
    check("fl_count_hold", hz.stall_count, 3);
    id_idle();
    tick(); tick(); tick();

    // flush beats load-use
    id_load(5'd8);
    tick();
    id_add(5'd9, 5'd8, 1, 5'd0, 0);
    hz.flush = 1; #1;
    check("fls_stall", hz.stall, 0);
    check("fls_bubble", hz.bubble, 1);
    tick();
    hz.flush = 0;
    check("fls_ex_rd", hz.id_ex_rd, 0);
    check("fls_ex_we", hz.id_ex_regwrite, 0);
    id_idle();
    tick(); tick();

    // $0 is never a destination
    id_add(5'd0, 5'd1, 1, 5'd2, 1);
    tick();
    check("r0_ex_we", hz.id_ex_regwrite, 0);
    id_add(5'd4, 5'd1, 1, 5'd2, 1);
    tick();
    check("r4_ex_we", hz.id_ex_regwrite, 1);
    id_idle();
    tick(); tick();

    // clear wins over a stall in the same cycle
    check("pre_clr_count", hz.stall_count, 3);
    id_load(5'd8);
    tick();
    id_add(5'd9, 5'd8, 1, 5'd0, 0);
    hz.cnt_clr = 1; #1;
    check("clr_stall", hz.stall, 1);
    tick();
    hz.cnt_clr = 0;
    check("clr_vs_stall", hz.stall_count, 0);
    id_idle();
    tick(); tick();

    // saturation on the 4-bit counter instance
    hz4.id_valid = 1; hz4.id_rd = 5'd4; hz4.id_regwrite = 1;
    hz4.id_memread = 1; hz4.id_memop = 1;
    tick();
    hz4.id_valid = 0; hz4.id_rd = 0; hz4.id_regwrite = 0;
    hz4.id_memread = 0; hz4.id_memop = 0;
    tick();
    hz4.mem_ready = 0;
    repeat (20) tick();
    check("sat_freeze", hz4.freeze, 1);
    check("sat_count", hz4.stall_count, 15);
    hz4.mem_ready = 1;

    // reset mid-freeze clears immediately; first edge after loads EX
    id_load(5'd5);
    tick();
    id_idle();
    tick();
    hz.mem_ready = 0; #1;
    check("mr_freeze", hz.freeze, 1);
    tick();
    check("mr_count_pre", hz.stall_count, 1);
    rst_n = 0; #1;
    check("mr_mem_rd", hz.ex_mem_rd, 0);
    check("mr_mem_we", hz.ex_mem_regwrite, 0);
    check("mr_count", hz.stall_count, 0);
    check("mr_freeze_rst", hz.freeze, 0);
    hz.mem_ready = 1;
    id_add(5'd10, 5'd1, 1, 5'd2, 1);
    @(negedge clk);
    rst_n = 1;
    tick();
    check("mr_first_ex", hz.id_ex_rd, 10);
    check("mr_first_we", hz.id_ex_regwrite, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
